// File: rtl/noc_inj_pkg.sv
// -----------------------------------------------------------------------------
// noc_inj_pkg
// Shared NoC definitions for the packet injector: size parameters, the flit
// format, the header overlay carried in a head flit's payload, the injector
// FSM encoding and a helper that builds a head flit.
//
// Size parameters (edit here, all users pick them up):
//   DATA_W    payload bits per flit
//   VC_NUM    number of virtual channels (VC field is clog2(VC_NUM), min 1)
//   MAX_BEATS maximum payload flits per packet (len field clog2(MAX_BEATS+1))
//   ID_X_W    X coordinate width
//   ID_Y_W    Y coordinate width
// -----------------------------------------------------------------------------
package noc_inj_pkg;

  localparam int DATA_W    = 64;
  localparam int VC_NUM    = 2;
  localparam int MAX_BEATS = 16;
  localparam int ID_X_W    = 3;
  localparam int ID_Y_W    = 3;

  localparam int VC_W  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int LEN_W = $clog2(MAX_BEATS + 1);
  localparam int HDR_W = 2 * ID_X_W + 2 * ID_Y_W + LEN_W;

  typedef enum logic [1:0] {
    FT_HEAD      = 2'd0,
    FT_BODY      = 2'd1,
    FT_TAIL      = 2'd2,
    FT_HEAD_TAIL = 2'd3
  } flit_type_e;

  typedef struct packed {
    flit_type_e        ftype;
    logic [VC_W-1:0]   vc;
    logic [DATA_W-1:0] payload;
  } noc_flit_t;

  // Head flit payload layout; len sits in the least significant bits.
  typedef struct packed {
    logic [DATA_W-HDR_W-1:0] rsvd;
    logic [ID_X_W-1:0]       dest_x;
    logic [ID_Y_W-1:0]       dest_y;
    logic [ID_X_W-1:0]       src_x;
    logic [ID_Y_W-1:0]       src_y;
    logic [LEN_W-1:0]        len;
  } noc_hdr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } inj_state_e;

  // Per-packet context latched when a request is accepted.
  typedef struct packed {
    logic [ID_X_W-1:0] dest_x;
    logic [ID_Y_W-1:0] dest_y;
    logic [ID_X_W-1:0] src_x;
    logic [ID_Y_W-1:0] src_y;
    logic [LEN_W-1:0]  len;
    logic [VC_W-1:0]   vc;
  } pkt_ctx_t;

  function automatic noc_flit_t make_head(input pkt_ctx_t ctx);
    noc_flit_t f;
    noc_hdr_t  hdr;
    hdr        = '0;
    hdr.dest_x = ctx.dest_x;
    hdr.dest_y = ctx.dest_y;
    hdr.src_x  = ctx.src_x;
    hdr.src_y  = ctx.src_y;
    hdr.len    = ctx.len;
    f.ftype    = (ctx.len == '0) ? FT_HEAD_TAIL : FT_HEAD;
    f.vc       = ctx.vc;
    f.payload  = hdr;
    return f;
  endfunction

endpackage

// File: rtl/noc_flit_out_reg.sv
// -----------------------------------------------------------------------------
// noc_flit_out_reg
// Single-entry output holding register towards the router local port.
// A loaded flit is presented (out_valid) straight away when its VC has buffer
// space in the load cycle; otherwise it is parked as pending and presented the
// cycle after its VC first reports space. Once presented, the flit is frozen
// until the fabric takes it, whatever vc_ready does meanwhile.
//
// Ports:
//   noc_clk, noc_rst  clock, asynchronous active-high reset
//   load, load_flit   write a new flit (honoured only when slot_free)
//   vc_ready          per-VC downstream buffer availability
//   out_ready         fabric accepts the presented flit
//   out_valid/out_flit presented flit
//   slot_free         a load this cycle will be taken
//   out_fire          out_valid && out_ready
//   perf_flits/perf_stall  (NOC_INJ_PERF_CNT_EN only) accepted flit count and
//                     stalled/pending cycle count, wrapping 32-bit
// Optional feature macro: NOC_INJ_PERF_CNT_EN
// -----------------------------------------------------------------------------
module noc_flit_out_reg
  import noc_inj_pkg::*;
(
  input  logic              noc_clk,
  input  logic              noc_rst,
  input  logic              load,
  input  noc_flit_t         load_flit,
  input  logic [VC_NUM-1:0] vc_ready,
  input  logic              out_ready,
  output logic              out_valid,
  output noc_flit_t         out_flit,
  output logic              slot_free,
  output logic              out_fire
`ifdef NOC_INJ_PERF_CNT_EN
  ,
  output logic [31:0]       perf_flits,
  output logic [31:0]       perf_stall
`endif
);

  logic      valid_q, valid_d;
  logic      pend_q, pend_d;
  noc_flit_t flit_q, flit_d;

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    valid_d   = valid_q;
    pend_d    = pend_q;
    flit_d    = flit_q;
    out_fire  = valid_q && out_ready;
    // A pending flit owns the slot even though it is not yet presented.
    slot_free = !pend_q && (!valid_q || out_ready);
    if (load && slot_free) begin
      flit_d  = load_flit;
      valid_d = vc_ready[load_flit.vc];
      pend_d  = !vc_ready[load_flit.vc];
    end else if (out_fire) begin
      valid_d = 1'b0;
    end else if (pend_q && vc_ready[flit_q.vc]) begin
      valid_d = 1'b1;
      pend_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the async reset clears the flit too so out_flit reads 0.
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
      flit_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pend_q  <= pend_d;
      flit_q  <= flit_d;
    end
  end

  assign out_valid = valid_q;
  assign out_flit  = flit_q;

`ifdef NOC_INJ_PERF_CNT_EN
  logic [31:0] perf_flits_q, perf_flits_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_flits_d = perf_flits_q + 32'(out_fire);
    perf_stall_d = perf_stall_q + 32'((valid_q && !out_ready) || pend_q);
  end

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      perf_flits_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_flits_q <= perf_flits_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_flits = perf_flits_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: rtl/noc_packet_injector.sv
// -----------------------------------------------------------------------------
// noc_packet_injector
// Source-side network interface of one mesh node. Accepts a packet request
// (destination, length, VC) and a payload beat stream, and emits a head flit
// followed by len body flits (last one typed TAIL) into the router local port,
// one flit per cycle when unstalled. Length mismatches between pay_last and
// req_len are repaired (zero fill or forced tail) and flagged on len_err.
//
// Ports:
//   noc_clk, noc_rst           clock, asynchronous active-high reset
//   src_x, src_y               this node's coordinates (static)
//   req_valid/req_ready        packet request handshake
//   req_dest_x/y, req_len, req_vc  request fields
//   pay_valid/pay_ready        payload beat handshake
//   pay_data, pay_last         payload beat and client end marker
//   out_valid/out_ready        flit handshake to the fabric
//   out_vc_ready               per-VC buffer availability
//   out_flit                   flit (noc_flit_t)
//   len_err                    one-cycle pulse on pay_last/req_len mismatch
//   perf_flits, perf_stall     (NOC_INJ_PERF_CNT_EN only) performance counters
// Optional feature macro: NOC_INJ_PERF_CNT_EN
// -----------------------------------------------------------------------------
module noc_packet_injector
  import noc_inj_pkg::*;
(
  input  logic              noc_clk,
  input  logic              noc_rst,
  input  logic [ID_X_W-1:0] src_x,
  input  logic [ID_Y_W-1:0] src_y,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ID_X_W-1:0] req_dest_x,
  input  logic [ID_Y_W-1:0] req_dest_y,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [VC_W-1:0]   req_vc,
  input  logic              pay_valid,
  output logic              pay_ready,
  input  logic [DATA_W-1:0] pay_data,
  input  logic              pay_last,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [VC_NUM-1:0] out_vc_ready,
  output noc_flit_t         out_flit,
  output logic              len_err
`ifdef NOC_INJ_PERF_CNT_EN
  ,
  output logic [31:0]       perf_flits,
  output logic [31:0]       perf_stall
`endif
);

  inj_state_e       state_q, state_d;
  pkt_ctx_t         ctx_q, ctx_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;     // payload flits loaded so far
  logic             fill_q, fill_d;   // zero-filling after an early pay_last

  logic      load;
  noc_flit_t load_flit;
  logic      slot_free;
  logic      out_fire;
  logic      beat_phase;
  logic      beats_left;
  logic      last_beat;

  always_comb begin
    state_d    = state_q;
    ctx_d      = ctx_q;
    cnt_d      = cnt_q;
    fill_d     = fill_q;
    load       = 1'b0;
    load_flit  = '0;
    req_ready  = 1'b0;
    pay_ready  = 1'b0;
    len_err    = 1'b0;
    beat_phase = 1'b0;
    beats_left = (cnt_q < ctx_q.len);
    last_beat  = (cnt_q == ctx_q.len - LEN_W'(1));

    case (state_q)
      ST_IDLE: begin
        req_ready = !noc_rst && slot_free;
        if (req_valid && req_ready) begin
          ctx_d.dest_x = req_dest_x;
          ctx_d.dest_y = req_dest_y;
          ctx_d.src_x  = src_x;
          ctx_d.src_y  = src_y;
          ctx_d.len    = req_len;
          ctx_d.vc     = req_vc;
          cnt_d        = '0;
          fill_d       = 1'b0;
          // The head is built from the request fields and loaded on the
          // accepting edge so it is presented the very next cycle.
          load         = 1'b1;
          load_flit    = make_head(ctx_d);
          state_d      = ST_HEAD;
        end
      end
      ST_HEAD: begin
        if (ctx_q.len == '0) begin
          if (out_fire) state_d = ST_IDLE;
        end else begin
          // Beats may already flow while the head sits in the output
          // register, which keeps head-to-first-body at full rate.
          beat_phase = 1'b1;
          state_d    = ST_BODY;
        end
      end
      ST_BODY: begin
        beat_phase = 1'b1;
        // With every payload flit loaded, the only flit left is the tail.
        if (!beats_left && out_fire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (beat_phase && beats_left) begin
      load_flit.ftype = last_beat ? FT_TAIL : FT_BODY;
      load_flit.vc    = ctx_q.vc;
      if (fill_q) begin
        // Client already ended the packet: pad with zeros at full rate.
        load_flit.payload = '0;
        if (slot_free) begin
          load  = 1'b1;
          cnt_d = cnt_q + LEN_W'(1);
        end
      end else begin
        load_flit.payload = pay_data;
        pay_ready         = slot_free;
        if (pay_valid && slot_free) begin
          load    = 1'b1;
          cnt_d   = cnt_q + LEN_W'(1);
          len_err = (pay_last != last_beat);
          if (pay_last && !last_beat) fill_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      state_q <= ST_IDLE;
      ctx_q   <= '0;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctx_q   <= ctx_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
    end
  end

  noc_flit_out_reg u_out_reg (
    .noc_clk   (noc_clk),
    .noc_rst   (noc_rst),
    .load      (load),
    .load_flit (load_flit),
    .vc_ready  (out_vc_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_flit  (out_flit),
    .slot_free (slot_free),
    .out_fire  (out_fire)
`ifdef NOC_INJ_PERF_CNT_EN
    ,
    .perf_flits(perf_flits),
    .perf_stall(perf_stall)
`endif
  );

endmodule

// File: tb/tb_noc_packet_injector.sv
// -----------------------------------------------------------------------------
// tb_noc_packet_injector
// Self-checking bench for noc_packet_injector. A packet-level reference model
// derives the expected flit list (header arithmetic, payload, zero fill, forced
// tail) and len_err count from the request and client behaviour.
// -----------------------------------------------------------------------------
module tb_noc_packet_injector;
  import noc_inj_pkg::*;

  localparam logic [ID_X_W-1:0] SRC_X = 3'd5;
  localparam logic [ID_Y_W-1:0] SRC_Y = 3'd6;

  logic              noc_clk;
  logic              noc_rst;
  logic              req_valid;
  logic              req_ready;
  logic [ID_X_W-1:0] req_dest_x;
  logic [ID_Y_W-1:0] req_dest_y;
  logic [LEN_W-1:0]  req_len;
  logic [VC_W-1:0]   req_vc;
  logic              pay_valid;
  logic              pay_ready;
  logic [DATA_W-1:0] pay_data;
  logic              pay_last;
  logic              out_valid;
  logic              out_ready;
  logic [VC_NUM-1:0] out_vc_ready;
  noc_flit_t         out_flit;
  logic              len_err;
`ifdef NOC_INJ_PERF_CNT_EN
  logic [31:0]       perf_flits;
  logic [31:0]       perf_stall;
`endif

  noc_packet_injector dut (
    .noc_clk     (noc_clk),
    .noc_rst     (noc_rst),
    .src_x       (SRC_X),
    .src_y       (SRC_Y),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_dest_x  (req_dest_x),
    .req_dest_y  (req_dest_y),
    .req_len     (req_len),
    .req_vc      (req_vc),
    .pay_valid   (pay_valid),
    .pay_ready   (pay_ready),
    .pay_data    (pay_data),
    .pay_last    (pay_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_vc_ready(out_vc_ready),
    .out_flit    (out_flit),
    .len_err     (len_err)
`ifdef NOC_INJ_PERF_CNT_EN
    ,
    .perf_flits  (perf_flits),
    .perf_stall  (perf_stall)
`endif
  );

  initial noc_clk = 1'b0;
  always #5 noc_clk = ~noc_clk;

  int cyc = 0;
  always @(posedge noc_clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Per-packet observations filled by drive_packet.
  logic [DATA_W-1:0] beats [MAX_BEATS];
  noc_flit_t         obs_q [$];
  int                obs_cyc [$];
  noc_flit_t         exp_q [$];
  int  req_cyc, err_cnt, err_cyc, last_cyc, unstable, blocked_valid;
  int  first_valid_cyc, last_tail_cyc;
  bit  timed_out;
  logic rr_at_tail;

  // Reference model: the flit list a packet must produce.
  function automatic void build_expected(input int dx, input int dy, input int len,
                                         input int vc, input int last_idx);
    noc_flit_t f;
    int        n_client;
    exp_q.delete();
    f.ftype   = (len == 0) ? FT_HEAD_TAIL : FT_HEAD;
    f.vc      = VC_W'(vc);
    f.payload = (64'(dx) << 14) | (64'(dy) << 11) | (64'(SRC_X) << 8) |
                (64'(SRC_Y) << 5) | 64'(len);
    exp_q.push_back(f);
    n_client = (last_idx >= 0 && last_idx < len) ? last_idx + 1 : len;
    for (int i = 0; i < len; i++) begin
      f.ftype   = (i == len - 1) ? FT_TAIL : FT_BODY;
      f.payload = (i < n_client) ? beats[i] : '0;
      exp_q.push_back(f);
    end
  endfunction

  function automatic int exp_errs(input int len, input int last_idx);
    return (len > 0 && last_idx != len - 1) ? 1 : 0;
  endfunction

  task automatic idle_inputs();
    @(negedge noc_clk);
    req_valid    = 1'b0;
    pay_valid    = 1'b0;
    pay_last     = 1'b0;
    out_ready    = 1'b1;
    out_vc_ready = '1;
  endtask

  // Client + fabric driver for one packet; records what the DUT emitted.
  task automatic drive_packet(input int dx, input int dy, input int len, input int vc,
                              input int last_idx, input int rdy_pct, input int vc_block,
                              input int gap_pct, input int hold_low, input int abort_after);
    int beat_idx, n_client, hold_left, start;
    bit req_done, prev_stall, done, req_fire, pay_fire;
    noc_flit_t prev_flit;
    obs_q.delete();
    obs_cyc.delete();
    req_cyc = -1; err_cnt = 0; err_cyc = -1; last_cyc = -1; unstable = 0;
    blocked_valid = 0; first_valid_cyc = -1; timed_out = 0; rr_at_tail = 1'bx;
    n_client  = (last_idx >= 0 && last_idx < len) ? last_idx + 1 : len;
    beat_idx  = 0; req_done = 0; hold_left = hold_low; prev_stall = 0; done = 0;
    prev_flit = '0; start = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge noc_clk);
      if (k == 0) start = cyc;
      req_valid    = !req_done;
      req_dest_x   = ID_X_W'(dx);
      req_dest_y   = ID_Y_W'(dy);
      req_len      = LEN_W'(len);
      req_vc       = VC_W'(vc);
      pay_valid    = req_done && (beat_idx < n_client) && ($urandom_range(99) >= gap_pct);
      pay_data     = beats[(beat_idx < MAX_BEATS) ? beat_idx : 0];
      pay_last     = (beat_idx == last_idx);
      out_vc_ready = '1;
      if (cyc - start < vc_block) out_vc_ready[vc] = 1'b0;
      if (out_valid && hold_left > 0) begin
        out_ready = 1'b0;
        hold_left--;
      end else begin
        out_ready = ($urandom_range(99) < rdy_pct);
      end
      #1;
      if (prev_stall && (!out_valid || out_flit !== prev_flit)) unstable++;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && (cyc - start < vc_block)) blocked_valid++;
      req_fire = req_valid && req_ready;
      pay_fire = pay_valid && pay_ready;
      if (req_fire) req_cyc = cyc;
      if (len_err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (pay_fire && pay_last) last_cyc = cyc;
      if (out_valid && out_ready) begin
        obs_q.push_back(out_flit);
        obs_cyc.push_back(cyc);
        if (out_flit.ftype == FT_TAIL || out_flit.ftype == FT_HEAD_TAIL) begin
          done          = 1;
          rr_at_tail    = req_ready;
          last_tail_cyc = cyc;
        end
        if (abort_after > 0 && obs_q.size() == abort_after) done = 1;
      end
      prev_stall = out_valid && !out_ready;
      prev_flit  = out_flit;
      @(posedge noc_clk);
      if (req_fire) req_done = 1;
      if (pay_fire) beat_idx++;
    end
    if (!done) timed_out = 1;
  endtask

  task automatic test_reset();
    noc_rst = 1'b1;
    req_valid = 1'b1; pay_valid = 1'b1; pay_last = 1'b0; pay_data = '0;
    req_dest_x = '0; req_dest_y = '0; req_len = '0; req_vc = '0;
    out_ready = 1'b1; out_vc_ready = '1;
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (out_flit !== '0) begin bad++; $display("FAIL rst_out_flit got=%h exp=0", out_flit); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
    total++; if (pay_ready !== 1'b0) begin bad++; $display("FAIL rst_pay_ready got=%b exp=0", pay_ready); end
    total++; if (len_err !== 1'b0) begin bad++; $display("FAIL rst_len_err got=%b exp=0", len_err); end
    repeat (2) @(negedge noc_clk);
    req_valid = 1'b0; pay_valid = 1'b0;
    noc_rst = 1'b0;
    @(negedge noc_clk); #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_rst_req_ready got=%b exp=1", req_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_rst_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_basic();
    beats[0] = 64'hA; beats[1] = 64'hB; beats[2] = 64'hC;
    drive_packet(2, 1, 3, 0, 2, 100, 0, 0, 0, 0);
    build_expected(2, 1, 3, 0, 2);
    total++; if (timed_out) begin bad++; $display("FAIL basic_timeout got=1 exp=0"); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL basic_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic_flit%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
      total++; if (obs_cyc[i] != req_cyc + 1 + i) begin bad++; $display("FAIL basic_cycle%0d got=%0d exp=%0d", i, obs_cyc[i], req_cyc + 1 + i); end
    end
    total++; if (err_cnt != 0) begin bad++; $display("FAIL basic_len_err got=%0d exp=0", err_cnt); end
    idle_inputs();
  endtask

  task automatic test_zero_len();
    drive_packet(4, 7, 0, 1, -1, 100, 0, 0, 0, 0);
    build_expected(4, 7, 0, 1, -1);
    total++; if (timed_out) begin bad++; $display("FAIL zlen_timeout got=1 exp=0"); end
    total++; if (obs_q.size() != 1) begin bad++; $display("FAIL zlen_count got=%0d exp=1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      total++; if (obs_q[0] !== exp_q[0]) begin bad++; $display("FAIL zlen_flit got=%h exp=%h", obs_q[0], exp_q[0]); end
    end
    total++; if (rr_at_tail !== 1'b0) begin bad++; $display("FAIL zlen_req_ready_t1 got=%b exp=0", rr_at_tail); end
    @(negedge noc_clk);
    req_valid = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL zlen_req_ready_t2 got=%b exp=1", req_ready); end
    total++; if (cyc != req_cyc + 2) begin bad++; $display("FAIL zlen_t2_cycle got=%0d exp=%0d", cyc, req_cyc + 2); end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) beats[i] = {$urandom, $urandom};
    drive_packet(1, 3, 4, 1, 3, 50, 5, 0, 0, 0);
    build_expected(1, 3, 4, 1, 3);
    total++; if (timed_out) begin bad++; $display("FAIL bp_timeout got=1 exp=0"); end
    total++; if (blocked_valid != 0) begin bad++; $display("FAIL bp_valid_while_blocked got=%0d exp=0", blocked_valid); end
    total++; if (first_valid_cyc != req_cyc + 6) begin bad++; $display("FAIL bp_first_valid got=%0d exp=%0d", first_valid_cyc, req_cyc + 6); end
    total++; if (unstable != 0) begin bad++; $display("FAIL bp_unstable got=%0d exp=0", unstable); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_flit%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    idle_inputs();
  endtask

  task automatic test_early_last();
    beats[0] = 64'h1111_AAAA; beats[1] = 64'h2222_BBBB; beats[2] = 64'h3333; beats[3] = 64'h4444;
    drive_packet(6, 2, 4, 0, 1, 100, 0, 0, 0, 0);
    build_expected(6, 2, 4, 0, 1);
    total++; if (timed_out) begin bad++; $display("FAIL early_timeout got=1 exp=0"); end
    total++; if (err_cnt != 1) begin bad++; $display("FAIL early_len_err_count got=%0d exp=1", err_cnt); end
    total++; if (err_cyc != last_cyc) begin bad++; $display("FAIL early_len_err_cycle got=%0d exp=%0d", err_cyc, last_cyc); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL early_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL early_flit%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    idle_inputs();
  endtask

  task automatic test_missing_last();
    for (int i = 0; i < 3; i++) beats[i] = {$urandom, $urandom};
    drive_packet(0, 5, 3, 1, -1, 100, 0, 0, 0, 0);
    build_expected(0, 5, 3, 1, -1);
    total++; if (timed_out) begin bad++; $display("FAIL miss_timeout got=1 exp=0"); end
    total++; if (err_cnt != 1) begin bad++; $display("FAIL miss_len_err_count got=%0d exp=1", err_cnt); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL miss_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL miss_flit%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_body();
    for (int i = 0; i < 8; i++) beats[i] = {$urandom, $urandom};
    drive_packet(3, 3, 8, 0, 7, 100, 0, 0, 0, 3);
    total++; if (obs_q.size() != 3) begin bad++; $display("FAIL mid_pre_count got=%0d exp=3", obs_q.size()); end
    @(negedge noc_clk);
    req_valid = 1'b1;
    #1;
    noc_rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_out_valid got=%b exp=0", out_valid); end
    total++; if (out_flit !== '0) begin bad++; $display("FAIL mid_rst_out_flit got=%h exp=0", out_flit); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_req_ready got=%b exp=0", req_ready); end
    total++; if (pay_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_pay_ready got=%b exp=0", pay_ready); end
    @(negedge noc_clk);
    req_valid = 1'b0; pay_valid = 1'b0;
    @(negedge noc_clk);
    noc_rst = 1'b0;
    beats[0] = 64'hDEAD_BEEF_0000_0001;
    drive_packet(7, 0, 1, 1, 0, 100, 0, 0, 0, 0);
    build_expected(7, 0, 1, 1, 0);
    total++; if (timed_out) begin bad++; $display("FAIL mid_post_timeout got=1 exp=0"); end
    total++; if (obs_q.size() != 2) begin bad++; $display("FAIL mid_post_count got=%0d exp=2", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL mid_post_flit%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int prev_tail;
    beats[0] = 64'h55; beats[1] = 64'h66;
    drive_packet(1, 1, 2, 0, 1, 100, 0, 0, 0, 0);
    prev_tail = last_tail_cyc;
    drive_packet(2, 2, 2, 1, 1, 100, 0, 0, 0, 0);
    build_expected(2, 2, 2, 1, 1);
    total++; if (req_cyc != prev_tail + 1) begin bad++; $display("FAIL b2b_req_cycle got=%0d exp=%0d", req_cyc, prev_tail + 1); end
    total++; if (obs_q.size() != 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_flit%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
      total++; if (obs_cyc[i] != prev_tail + 2 + i) begin bad++; $display("FAIL b2b_cycle%0d got=%0d exp=%0d", i, obs_cyc[i], prev_tail + 2 + i); end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    int len, vc, dx, dy, last_idx, r;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(MAX_BEATS);
      vc  = $urandom_range(VC_NUM - 1);
      dx  = $urandom_range(7);
      dy  = $urandom_range(7);
      r   = $urandom_range(99);
      if (r < 70 || len < 2) last_idx = len - 1;
      else if (r < 85)       last_idx = $urandom_range(len - 2);
      else                   last_idx = -1;
      for (int i = 0; i < MAX_BEATS; i++) beats[i] = {$urandom, $urandom};
      drive_packet(dx, dy, len, vc, last_idx, $urandom_range(100, 60),
                   $urandom_range(3), $urandom_range(30), 0, 0);
      build_expected(dx, dy, len, vc, last_idx);
      total++; if (timed_out) begin bad++; $display("FAIL rnd%0d_timeout got=1 exp=0", p); end
      total++; if (err_cnt != exp_errs(len, last_idx)) begin bad++; $display("FAIL rnd%0d_len_err got=%0d exp=%0d", p, err_cnt, exp_errs(len, last_idx)); end
      total++; if (unstable != 0) begin bad++; $display("FAIL rnd%0d_unstable got=%0d exp=0", p, unstable); end
      total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd%0d_count got=%0d exp=%0d", p, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd%0d_flit%0d got=%h exp=%h", p, i, obs_q[i], exp_q[i]); end
      end
    end
    idle_inputs();
  endtask

`ifdef NOC_INJ_PERF_CNT_EN
  task automatic test_perf();
    logic [31:0] f0, s0;
    @(negedge noc_clk); #1;
    f0 = perf_flits;
    s0 = perf_stall;
    beats[0] = 64'h1; beats[1] = 64'h2;
    drive_packet(1, 2, 2, 0, 1, 100, 0, 0, 3, 0);
    drive_packet(2, 1, 2, 1, 1, 100, 0, 0, 0, 0);
    idle_inputs();
    #1;
    total++; if (perf_flits - f0 !== 32'd6) begin bad++; $display("FAIL perf_flits got=%0d exp=6", perf_flits - f0); end
    total++; if (perf_stall - s0 !== 32'd3) begin bad++; $display("FAIL perf_stall got=%0d exp=3", perf_stall - s0); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_back_to_back();
    test_random();
`ifdef NOC_INJ_PERF_CNT_EN
    test_perf();
`endif
    test_reset_mid_body();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
